// File: rtl/common.sv
// Shared types for the data-memory path: identifies which requester owns an in-flight read.
package common;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_DBG  = 2'd2
  } dmem_owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU MA stage (priority) and a debug/DMA master.
// Latency: grant and dmem_* are combinational; read valid is tagged back one cycle after issue.
// Backpressure: dbg waits on dbg_ready_o; with DMEM_ARB_FAIRNESS_EN the CPU is stalled one cycle per forced grant.
module dmem_arbiter
  import common::*;
#(
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_read_enable_i,
  input  logic [31:0] cpu_write_data_i,
  input  logic [3:0]  cpu_write_mask_i,
  output logic        cpu_ready_o,
  output logic [31:0] cpu_read_data_o,
  output logic        cpu_read_valid_o,
  input  logic        dbg_valid_i,
  input  logic [31:0] dbg_addr_i,
  input  logic        dbg_read_enable_i,
  input  logic [31:0] dbg_write_data_i,
  input  logic [3:0]  dbg_write_mask_i,
  output logic        dbg_ready_o,
  output logic [31:0] dbg_read_data_o,
  output logic        dbg_read_valid_o,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_read_enable_o,
  output logic [31:0] dmem_write_data_o,
  output logic [3:0]  dmem_write_mask_o,
  input  logic [31:0] dmem_read_data_i
);

  if (MAX_CPU_STREAK < 1) begin : g_bad_streak
    $error("MAX_CPU_STREAK must be at least 1");
  end

  logic        cpu_req;
  logic        force_dbg;
  logic        grant_cpu;
  logic        grant_dbg;
  dmem_owner_t rd_owner_r;

  assign cpu_req   = cpu_read_enable_i | (|cpu_write_mask_i);
  assign grant_cpu = cpu_req & ~force_dbg;
  assign grant_dbg = dbg_valid_i & ~grant_cpu;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam int                  STREAK_W   = $clog2(MAX_CPU_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

  logic [STREAK_W-1:0] streak_r;

  assign force_dbg   = dbg_valid_i & (streak_r == STREAK_MAX);
  assign cpu_ready_o = ~force_dbg;

  // Counts CPU wins that made the secondary wait; saturates rather than wrapping.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      streak_r <= '0;
    end else if (!dbg_valid_i || grant_dbg) begin
      streak_r <= '0;
    end else if (grant_cpu && (streak_r != STREAK_MAX)) begin
      streak_r <= streak_r + STREAK_W'(1);
    end
  end
`else
  assign force_dbg   = 1'b0;
  assign cpu_ready_o = 1'b1;
`endif

  assign dbg_ready_o = grant_dbg;

  always_comb begin
    dmem_addr_o        = '0;
    dmem_read_enable_o = 1'b0;
    dmem_write_data_o  = '0;
    dmem_write_mask_o  = '0;
    if (grant_cpu) begin
      dmem_addr_o        = cpu_addr_i;
      dmem_read_enable_o = cpu_read_enable_i;
      dmem_write_data_o  = cpu_write_data_i;
      dmem_write_mask_o  = cpu_write_mask_i;
    end else if (grant_dbg) begin
      // A secondary access is either a read or a write, never both.
      dmem_addr_o        = dbg_addr_i;
      dmem_read_enable_o = dbg_read_enable_i;
      dmem_write_data_o  = dbg_write_data_i;
      dmem_write_mask_o  = dbg_read_enable_i ? 4'b0000 : dbg_write_mask_i;
    end
  end

  // Tag of the read whose data appears on dmem_read_data_i next cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_owner_r <= OWNER_NONE;
    end else if (grant_cpu && cpu_read_enable_i) begin
      rd_owner_r <= OWNER_CPU;
    end else if (grant_dbg && dbg_read_enable_i) begin
      rd_owner_r <= OWNER_DBG;
    end else begin
      rd_owner_r <= OWNER_NONE;
    end
  end

  assign cpu_read_data_o  = dmem_read_data_i;
  assign dbg_read_data_o  = dmem_read_data_i;
  assign cpu_read_valid_o = (rd_owner_r == OWNER_CPU);
  assign dbg_read_valid_o = (rd_owner_r == OWNER_DBG);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import common::*;

  localparam int MAXS = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk_i;
  logic        reset_ni;
  logic [31:0] cpu_addr_i;
  logic        cpu_read_enable_i;
  logic [31:0] cpu_write_data_i;
  logic [3:0]  cpu_write_mask_i;
  logic        cpu_ready_o;
  logic [31:0] cpu_read_data_o;
  logic        cpu_read_valid_o;
  logic        dbg_valid_i;
  logic [31:0] dbg_addr_i;
  logic        dbg_read_enable_i;
  logic [31:0] dbg_write_data_i;
  logic [3:0]  dbg_write_mask_i;
  logic        dbg_ready_o;
  logic [31:0] dbg_read_data_o;
  logic        dbg_read_valid_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_read_enable_o;
  logic [31:0] dmem_write_data_o;
  logic [3:0]  dmem_write_mask_o;
  logic [31:0] dmem_read_data_i;

  dmem_arbiter #(.MAX_CPU_STREAK(MAXS)) dut (
    .clk_i             (clk_i),
    .reset_ni          (reset_ni),
    .cpu_addr_i        (cpu_addr_i),
    .cpu_read_enable_i (cpu_read_enable_i),
    .cpu_write_data_i  (cpu_write_data_i),
    .cpu_write_mask_i  (cpu_write_mask_i),
    .cpu_ready_o       (cpu_ready_o),
    .cpu_read_data_o   (cpu_read_data_o),
    .cpu_read_valid_o  (cpu_read_valid_o),
    .dbg_valid_i       (dbg_valid_i),
    .dbg_addr_i        (dbg_addr_i),
    .dbg_read_enable_i (dbg_read_enable_i),
    .dbg_write_data_i  (dbg_write_data_i),
    .dbg_write_mask_i  (dbg_write_mask_i),
    .dbg_ready_o       (dbg_ready_o),
    .dbg_read_data_o   (dbg_read_data_o),
    .dbg_read_valid_o  (dbg_read_valid_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_read_enable_o(dmem_read_enable_o),
    .dmem_write_data_o (dmem_write_data_o),
    .dmem_write_mask_o (dmem_write_mask_o),
    .dmem_read_data_i  (dmem_read_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Data BRAM behind the arbiter (one-cycle read latency).
  logic [31:0] mem [0:255];
  always @(posedge clk_i) begin
    if (dmem_read_enable_o) dmem_read_data_i <= mem[dmem_addr_o[9:2]];
    for (int b = 0; b < 4; b++)
      if (dmem_write_mask_o[b]) mem[dmem_addr_o[9:2]][8*b +: 8] <= dmem_write_data_o[8*b +: 8];
  end

  // Reference state: expected memory contents, CPU streak, outstanding reads.
  logic [31:0] mmem [0:255];
  int          streak_m;
  typedef struct {
    int          ret;
    bit          is_cpu;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  int cyc;
  int checks;
  int errors;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of requests, checks the combinational port against the model, updates the model.
  task automatic step(input logic cre, input logic [7:0] cidx, input logic [3:0] cmask,
                      input logic [31:0] cwd, input logic dv, input logic dre,
                      input logic [7:0] didx, input logic [3:0] dmask, input logic [31:0] dwd,
                      output logic acc);
    logic        creq, frc, gc, gd, ere;
    logic [31:0] ea;
    logic [3:0]  em;
    logic [31:0] ewd;
    @(negedge clk_i);
    #2;
    cpu_addr_i        = {22'd0, cidx, 2'b00};
    cpu_read_enable_i = cre;
    cpu_write_mask_i  = cmask;
    cpu_write_data_i  = cwd;
    dbg_valid_i       = dv;
    dbg_addr_i        = {22'd0, didx, 2'b00};
    dbg_read_enable_i = dre;
    dbg_write_mask_i  = dmask;
    dbg_write_data_i  = dwd;
    #1;
    creq = cre | (|cmask);
    frc  = FAIR && dv && (streak_m == MAXS);
    gc   = creq && !frc;
    gd   = dv && !gc;
    ea   = gc ? cpu_addr_i : (gd ? dbg_addr_i : 32'd0);
    ere  = gc ? cre : (gd ? dre : 1'b0);
    em   = gc ? cmask : ((gd && !dre) ? dmask : 4'b0000);
    ewd  = gc ? cwd : dwd;
    chk("dmem_addr", dmem_addr_o, ea);
    chk("dmem_read_enable", {31'd0, dmem_read_enable_o}, {31'd0, ere});
    chk("dmem_write_mask", {28'd0, dmem_write_mask_o}, {28'd0, em});
    if (em != 4'b0000) chk("dmem_write_data", dmem_write_data_o, ewd);
    chk("cpu_ready", {31'd0, cpu_ready_o}, {31'd0, !frc});
    chk("dbg_ready", {31'd0, dbg_ready_o}, {31'd0, gd});
    if (reset_ni) begin
      if (gc && cre) q.push_back('{ret: cyc + 1, is_cpu: 1'b1, data: mmem[cidx]});
      if (gd && dre) q.push_back('{ret: cyc + 1, is_cpu: 1'b0, data: mmem[didx]});
    end
    for (int b = 0; b < 4; b++) begin
      if (em[b]) begin
        if (gc) mmem[cidx][8*b +: 8] = cwd[8*b +: 8];
        else    mmem[didx][8*b +: 8] = dwd[8*b +: 8];
      end
    end
    acc = gd;
    @(posedge clk_i);
    if (!reset_ni || !dv || gd) streak_m = 0;
    else if (streak_m < MAXS) streak_m++;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 4'd0, 32'd0, 1'b0, 1'b0, 8'd0, 4'd0, 32'd0, a);
  endtask

  // Monitor: every returned read must match the oldest outstanding expectation for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (q.size() > 0 && q[0].ret == cyc) begin
        e = q.pop_front();
        chk("cpu_read_valid", {31'd0, cpu_read_valid_o}, {31'd0, e.is_cpu});
        chk("dbg_read_valid", {31'd0, dbg_read_valid_o}, {31'd0, !e.is_cpu});
        chk(e.is_cpu ? "cpu_read_data" : "dbg_read_data",
            e.is_cpu ? cpu_read_data_o : dbg_read_data_o, e.data);
      end else begin
        chk("no_cpu_read_valid", {31'd0, cpu_read_valid_o}, 32'd0);
        chk("no_dbg_read_valid", {31'd0, dbg_read_valid_o}, 32'd0);
      end
    end
  end

  initial begin
    logic        acc, dv, dre;
    logic [7:0]  didx;
    logic [3:0]  dmask;
    logic [31:0] dwd;
    int          op;
    checks = 0; errors = 0; cyc = 0; streak_m = 0;
    reset_ni = 1'b0;
    cpu_addr_i = '0; cpu_read_enable_i = 1'b0; cpu_write_data_i = '0; cpu_write_mask_i = '0;
    dbg_valid_i = 1'b0; dbg_addr_i = '0; dbg_read_enable_i = 1'b0;
    dbg_write_data_i = '0; dbg_write_mask_i = '0; dmem_read_data_i = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = $urandom;
      mmem[i] = mem[i];
    end
    mem[64]  = 32'hDEADBEEF;
    mmem[64] = 32'hDEADBEEF;

    // Ready behaviour while held in reset
    step(1'b0, 8'd5, 4'd0, 32'd0, 1'b1, 1'b1, 8'd6, 4'd0, 32'd0, acc);
    step(1'b1, 8'd5, 4'd0, 32'd0, 1'b1, 1'b1, 8'd6, 4'd0, 32'd0, acc);
    idle(1);
    @(negedge clk_i); #2; reset_ni = 1'b1;

    // Idle CPU, secondary read of 0x100
    step(1'b0, 8'd0, 4'd0, 32'd0, 1'b1, 1'b1, 8'd64, 4'd0, 32'd0, acc);
    idle(2);

    // Contention on writes (and forced grant when fairness is built in)
    dv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'd128, 4'hF, $urandom, dv, 1'b0, 8'd192, 4'hF, 32'hA5A5_0300, acc);
      if (acc) dv = 1'b0;
    end
    // Continuous CPU reads with a pending secondary read
    dv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(10 + i), 4'd0, 32'd0, dv, 1'b1, 8'd20, 4'd0, 32'd0, acc);
      if (acc) dv = 1'b0;
    end
    idle(2);

    // Alternating CPU / secondary reads
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(30 + i), 4'd0, 32'd0, 1'b0, 1'b0, 8'd0, 4'd0, 32'd0, acc);
      step(1'b0, 8'd0, 4'd0, 32'd0, 1'b1, 1'b1, 8'(40 + i), 4'd0, 32'd0, acc);
    end

    // Write-only secondary, then read the result back through the CPU
    step(1'b0, 8'd0, 4'd0, 32'd0, 1'b1, 1'b0, 8'd50, 4'b0011, 32'h1234_5678, acc);
    step(1'b1, 8'd50, 4'd0, 32'd0, 1'b0, 1'b0, 8'd0, 4'd0, 32'd0, acc);
    idle(2);

    // Reset asserted while a CPU read is in flight
    step(1'b1, 8'd60, 4'd0, 32'd0, 1'b0, 1'b0, 8'd0, 4'd0, 32'd0, acc);
    #1;
    reset_ni = 1'b0;
    q.delete();
    streak_m = 0;
    step(1'b0, 8'd0, 4'd0, 32'd0, 1'b1, 1'b1, 8'd61, 4'd0, 32'd0, acc);
    idle(1);
    @(negedge clk_i); #2; reset_ni = 1'b1;
    idle(3);

    // Randomized traffic; the secondary holds its request until accepted
    dv = 1'b0; dre = 1'b0; didx = '0; dmask = '0; dwd = '0; acc = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (!dv || acc) begin
        dv    = ($urandom_range(0, 99) < 60);
        dre   = 1'($urandom_range(0, 1));
        didx  = 8'($urandom_range(0, 63));
        dmask = 4'($urandom_range(0, 15));
        dwd   = $urandom;
      end
      op = $urandom_range(0, 3);
      step(op == 1 || op == 3, 8'($urandom_range(0, 63)),
           (op == 2) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom,
           dv, dre, didx, dmask, dwd, acc);
    end
    idle(4);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads outstanding, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
